// File: rtl/burst_shift_register.sv
// Universal shift register that runs multi-step bursts of S-bit shifts or rotates.
// A single start command launches the burst; busy/done report progress and sOut shows the bits that left Q.
module burst_shift_register #(
  parameter int N  = 8,
  parameter int S  = 1,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [N-1:0]  D,
  input  logic          load,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] count,
  input  logic [S-1:0]  dSerial,
  input  logic          abort,
  output logic [N-1:0]  Q,
  output logic [S-1:0]  sOut,
  output logic          busy,
  output logic          done
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state, state_next;
  logic [2:0]    mode_reg, mode_next;
  logic [CW-1:0] remaining, remaining_next;
  logic [N-1:0]  q_next, step_q;
  logic [S-1:0]  sout_next, step_s;
  logic          done_next;

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      mode_reg  <= 3'b000;
      remaining <= '0;
      Q         <= '0;
      sOut      <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      mode_reg  <= mode_next;
      remaining <= remaining_next;
      Q         <= q_next;
      sOut      <= sout_next;
      done      <= done_next;
    end
  end

  // One step of the latched mode; unused mode codes leave Q and sOut alone.
  always_comb begin
    step_q = Q;
    step_s = sOut;
    case (mode_reg)
      3'b000: begin
        step_q = {Q[N-1-S:0], dSerial};
        step_s = Q[N-1 -: S];
      end
      3'b001: begin
        step_q = {dSerial, Q[N-1:S]};
        step_s = Q[S-1:0];
      end
      3'b010: begin
        step_q = {Q[N-1-S:0], Q[N-1 -: S]};
        step_s = Q[N-1 -: S];
      end
      3'b011: begin
        step_q = {Q[S-1:0], Q[N-1:S]};
        step_s = Q[S-1:0];
      end
      3'b100: begin
        step_q = {{S{Q[N-1]}}, Q[N-1:S]};
        step_s = Q[S-1:0];
      end
      default: begin
        step_q = Q;
        step_s = sOut;
      end
    endcase
  end

  always_comb begin
    state_next     = state;
    mode_next      = mode_reg;
    remaining_next = remaining;
    q_next         = Q;
    sout_next      = sOut;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          q_next = D;
        end else if (start) begin
          if (count == '0) begin
            done_next = 1'b1;
          end else begin
            mode_next      = mode;
            remaining_next = count;
            state_next     = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          remaining_next = '0;
          state_next     = IDLE;
        end else begin
          q_next    = step_q;
          sout_next = step_s;
          if (remaining != '0) begin
            remaining_next = remaining - 1'b1;
          end
          // The last step returns to IDLE and flags completion on the same edge.
          if (remaining == {{(CW-1){1'b0}}, 1'b1}) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_burst_shift_register.sv
// Scoreboard bench for burst_shift_register: two instances (S=1 and S=2) share stimulus,
// expectations are queued after each edge and a monitor compares them on the falling edge.
module tb_burst_shift_register;

  logic       clk;
  logic       clr;
  logic [7:0] d;
  logic       load;
  logic       start;
  logic [2:0] mode;
  logic [3:0] count;
  logic       dserial1;
  logic [1:0] dserial2;
  logic       abort;
  logic [7:0] q1, q2;
  logic       sout1;
  logic [1:0] sout2;
  logic       busy1, busy2, done1, done2;

  typedef struct {
    string      name;
    int         which;
    logic [7:0] q;
    logic [1:0] s;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  burst_shift_register #(.N(8), .S(1), .CW(4)) dut1 (
    .clk(clk), .clr(clr), .D(d), .load(load), .start(start), .mode(mode),
    .count(count), .dSerial(dserial1), .abort(abort),
    .Q(q1), .sOut(sout1), .busy(busy1), .done(done1)
  );

  burst_shift_register #(.N(8), .S(2), .CW(4)) dut2 (
    .clk(clk), .clr(clr), .D(d), .load(load), .start(start), .mode(mode),
    .count(count), .dSerial(dserial2), .abort(abort),
    .Q(q2), .sOut(sout2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string name, input int which, input logic [7:0] q,
                            input logic [1:0] s, input logic b, input logic dn);
    exp_t e;
    e.name  = name;
    e.which = which;
    e.q     = q;
    e.s     = s;
    e.busy  = b;
    e.done  = dn;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: everything queued since the last rising edge is checked half a cycle later.
  initial begin
    exp_t       e;
    logic [7:0] aq;
    logic [1:0] as;
    logic       ab, ad;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.which == 1) begin
          aq = q1; as = {1'b0, sout1}; ab = busy1; ad = done1;
        end else begin
          aq = q2; as = sout2; ab = busy2; ad = done2;
        end
        tests_run++;
        if (aq !== e.q || as !== e.s || ab !== e.busy || ad !== e.done) begin
          tests_failed++;
          $display("[TB] FAIL %s (dut%0d): got Q=%h sOut=%b busy=%b done=%b, want Q=%h sOut=%b busy=%b done=%b",
                   e.name, e.which, aq, as, ab, ad, e.q, e.s, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr = 1'b0; d = '0; load = 1'b0; start = 1'b0; mode = '0; count = '0;
    dserial1 = 1'b0; dserial2 = '0; abort = 1'b0;
    #1;
    expect_out("reset", 1, 8'h00, 2'b00, 1'b0, 1'b0);
    expect_out("reset", 2, 8'h00, 2'b00, 1'b0, 1'b0);
    tick(); tick();
    clr = 1'b1;

    d = 8'hA5; load = 1'b1; tick(); load = 1'b0;
    expect_out("load_a5", 1, 8'hA5, 2'b00, 1'b0, 1'b0);
    expect_out("load_a5", 2, 8'hA5, 2'b00, 1'b0, 1'b0);

    // ROL by one, three steps
    mode = 3'b010; count = 4'd3; start = 1'b1; tick(); start = 1'b0;
    expect_out("rol_start", 1, 8'hA5, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("rol_step1", 1, 8'h4B, 2'b01, 1'b1, 1'b0);
    tick(); expect_out("rol_step2", 1, 8'h96, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("rol_step3", 1, 8'h2D, 2'b01, 1'b0, 1'b1);
    expect_out("rol2_step3", 2, 8'h69, 2'b01, 1'b0, 1'b1);
    tick(); expect_out("rol_after", 1, 8'h2D, 2'b01, 1'b0, 1'b0);

    // ASR, checked mainly on the two-bit instance
    d = 8'h90; load = 1'b1; tick(); load = 1'b0;
    expect_out("load_90", 1, 8'h90, 2'b01, 1'b0, 1'b0);
    mode = 3'b100; count = 4'd2; start = 1'b1; tick(); start = 1'b0;
    expect_out("asr_start", 2, 8'h90, 2'b01, 1'b1, 1'b0);
    tick(); expect_out("asr_step1", 2, 8'hE4, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("asr_step2", 2, 8'hF9, 2'b00, 1'b0, 1'b1);
    expect_out("asr1_step2", 1, 8'hE4, 2'b00, 1'b0, 1'b1);
    tick(); expect_out("asr_after", 2, 8'hF9, 2'b00, 1'b0, 1'b0);

    // LSL fill with ones; load/start mid-burst must be ignored
    d = 8'h00; load = 1'b1; tick(); load = 1'b0;
    expect_out("load_00", 1, 8'h00, 2'b00, 1'b0, 1'b0);
    mode = 3'b000; count = 4'd4; dserial1 = 1'b1; dserial2 = 2'b11; start = 1'b1;
    tick(); start = 1'b0;
    expect_out("lsl_start", 1, 8'h00, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("lsl_step1", 1, 8'h01, 2'b00, 1'b1, 1'b0);
    d = 8'hFF; load = 1'b1; start = 1'b1; count = 4'd0; mode = 3'b010;
    tick(); expect_out("lsl_step2", 1, 8'h03, 2'b00, 1'b1, 1'b0);
    load = 1'b0; start = 1'b0;
    tick(); expect_out("lsl_step3", 1, 8'h07, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("lsl_step4", 1, 8'h0F, 2'b00, 1'b0, 1'b1);
    tick(); expect_out("lsl_after", 1, 8'h0F, 2'b00, 1'b0, 1'b0);

    // Zero-length burst
    count = 4'd0; start = 1'b1; tick(); start = 1'b0;
    expect_out("zero_done", 1, 8'h0F, 2'b00, 1'b0, 1'b1);
    tick(); expect_out("zero_after", 1, 8'h0F, 2'b00, 1'b0, 1'b0);

    // Abort on the second step edge
    d = 8'h01; load = 1'b1; dserial1 = 1'b0; tick(); load = 1'b0;
    expect_out("load_01", 1, 8'h01, 2'b00, 1'b0, 1'b0);
    mode = 3'b000; count = 4'd5; start = 1'b1; tick(); start = 1'b0;
    expect_out("abort_start", 1, 8'h01, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("abort_step1", 1, 8'h02, 2'b00, 1'b1, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    expect_out("abort_edge", 1, 8'h02, 2'b00, 1'b0, 1'b0);
    tick(); expect_out("abort_nodone", 1, 8'h02, 2'b00, 1'b0, 1'b0);

    // LSR, ROR and a reserved mode
    d = 8'h81; load = 1'b1; tick(); load = 1'b0;
    expect_out("load_81", 1, 8'h81, 2'b00, 1'b0, 1'b0);
    mode = 3'b001; count = 4'd1; dserial1 = 1'b1; start = 1'b1; tick(); start = 1'b0;
    expect_out("lsr_start", 1, 8'h81, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("lsr_step", 1, 8'hC0, 2'b01, 1'b0, 1'b1);
    mode = 3'b011; count = 4'd1; start = 1'b1; tick(); start = 1'b0;
    expect_out("ror_start", 1, 8'hC0, 2'b01, 1'b1, 1'b0);
    tick(); expect_out("ror_step", 1, 8'h60, 2'b00, 1'b0, 1'b1);
    mode = 3'b101; count = 4'd2; start = 1'b1; tick(); start = 1'b0;
    expect_out("nop_start", 1, 8'h60, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("nop_step1", 1, 8'h60, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("nop_step2", 1, 8'h60, 2'b00, 1'b0, 1'b1);

    // Asynchronous clear in the middle of a burst
    d = 8'h01; load = 1'b1; dserial1 = 1'b0; tick(); load = 1'b0;
    expect_out("load_01b", 1, 8'h01, 2'b00, 1'b0, 1'b0);
    mode = 3'b000; count = 4'd5; start = 1'b1; tick(); start = 1'b0;
    expect_out("clr_start", 1, 8'h01, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("clr_step1", 1, 8'h02, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("clr_step2", 1, 8'h04, 2'b00, 1'b1, 1'b0);
    tick(); expect_out("clr_step3", 1, 8'h08, 2'b00, 1'b1, 1'b0);
    @(negedge clk); #1;
    clr = 1'b0; #1;
    expect_out("clr_async", 1, 8'h00, 2'b00, 1'b0, 1'b0);
    expect_out("clr_async", 2, 8'h00, 2'b00, 1'b0, 1'b0);
    @(negedge clk); #1;
    tick(); expect_out("clr_nodone", 1, 8'h00, 2'b00, 1'b0, 1'b0);
    clr = 1'b1;
    tick(); expect_out("clr_idle", 1, 8'h00, 2'b00, 1'b0, 1'b0);

    tick(); tick();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
